// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU.
//   op_e    : 4-bit opcode encoding (values 13..15 are reserved)
//   FLAG_*  : bit positions inside the {C,V,N,Z} flags word
//   state_e : control FSM encoding (IDLE / MUL)
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_ROL  = 4'd2,
        OP_ROR  = 4'd3,
        OP_AND  = 4'd4,
        OP_NAND = 4'd5,
        OP_NOR  = 4'd6,
        OP_OR   = 4'd7,
        OP_XOR  = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_SRA  = 4'd11,
        OP_MUL  = 4'd12
    } op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
//   clk, rst_n : clock, synchronous active-low reset (control only)
//   start_i    : load operands and begin (ignored while busy)
//   a_i, b_i   : multiplicand / multiplier
//   busy_o     : iteration in progress
//   done_o     : final iteration this cycle; prod_o is the full product now
//   prod_o     : 2*WIDTH-bit product, valid while done_o is high
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int CW = $clog2(WIDTH);

    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_d;

    assign addend = mplier_q[0] ? mcand_q : '0;
    assign acc_d  = acc_q + addend;

    // The last partial product is folded in combinationally so the product
    // is complete in the same cycle done_o is raised.
    assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign prod_o = acc_d;
    assign busy_o = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i && !busy_q) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_i && !busy_q) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Single-output-register ALU with valid/ready handshakes. Logic, add/sub,
// shift and rotate ops complete in one cycle; MUL runs on alu_mul_seq.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : request handshake carrying a, b, op
//   a, b                : operands (b[SHW-1:0] is the shift/rotate amount)
//   op                  : opcode (alu_pkg::op_e)
//   out_valid/out_ready : result handshake
//   result, result_hi   : low word, high product word (MUL only, else 0)
//   flags               : {C,V,N,Z}
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                              input logic [SHW-1:0]   r);
        logic [2*WIDTH-1:0] d;
        d = {x, x} << r;
        return d[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                              input logic [SHW-1:0]   r);
        logic [2*WIDTH-1:0] d;
        d = {x, x} >> r;
        return d[WIDTH-1:0];
    endfunction

    state_e             state_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic [3:0]         flags_q;

    op_e                op_sel;
    logic               accept;
    logic               is_mul;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_lo;
    logic [WIDTH-1:0]   mul_hi;
    logic [3:0]         mul_flags;

    logic [SHW-1:0]     sh_amt;
    logic [SHW-1:0]     rot_amt;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;
    logic signed [WIDTH:0] sra_w;
    logic [WIDTH-1:0]   rol_w;
    logic [WIDTH-1:0]   ror_w;

    logic [WIDTH-1:0]   res_d;
    logic               c_d;
    logic               v_d;
    logic [3:0]         flags_d;

    assign op_sel   = op_e'(op);
    assign is_mul   = (op_sel == OP_MUL);
    // Gated with rst_n so no request is taken during the reset cycle.
    assign in_ready = rst_n && (state_q == ST_IDLE) && !mul_busy
                      && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept && is_mul),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    assign mul_lo = mul_prod[WIDTH-1:0];
    assign mul_hi = mul_prod[2*WIDTH-1:WIDTH];

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_C] = |mul_hi;
        mul_flags[FLAG_V] = |mul_hi;
        mul_flags[FLAG_N] = mul_lo[MSB];
        mul_flags[FLAG_Z] = (mul_prod == '0);
    end

    // Each shift carries one extra bit on the side data leaves, so that bit
    // is the last one shifted out (and 0 when the amount is 0).
    assign sh_amt  = b[SHW-1:0];
    assign rot_amt = SHW'(32'(sh_amt) % WIDTH);
    assign sum_w   = {1'b0, a} + {1'b0, b};
    assign diff_w  = {1'b0, a} - {1'b0, b};
    assign shl_w   = {1'b0, a} << sh_amt;
    assign shr_w   = {a, 1'b0} >> sh_amt;
    assign sra_w   = $signed({a, 1'b0}) >>> sh_amt;
    assign rol_w   = rotl(a, rot_amt);
    assign ror_w   = rotr(a, rot_amt);

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (op_sel)
            OP_ADD: begin
                res_d = sum_w[WIDTH-1:0];
                c_d   = sum_w[WIDTH];
                v_d   = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
            end
            OP_SUB: begin
                res_d = diff_w[WIDTH-1:0];
                c_d   = diff_w[WIDTH];
                v_d   = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
            end
            OP_ROL: begin
                res_d = rol_w;
                c_d   = (rot_amt != '0) && rol_w[0];
            end
            OP_ROR: begin
                res_d = ror_w;
                c_d   = (rot_amt != '0) && ror_w[MSB];
            end
            OP_AND:  res_d = a & b;
            OP_NAND: res_d = ~(a & b);
            OP_NOR:  res_d = ~(a | b);
            OP_OR:   res_d = a | b;
            OP_XOR:  res_d = a ^ b;
            OP_SHL: begin
                res_d = shl_w[WIDTH-1:0];
                c_d   = shl_w[WIDTH];
            end
            OP_SHR: begin
                res_d = shr_w[WIDTH:1];
                c_d   = shr_w[0];
            end
            OP_SRA: begin
                res_d = sra_w[WIDTH:1];
                c_d   = sra_w[0];
            end
            default: begin
                res_d = '0;
            end
        endcase
        flags_d         = '0;
        flags_d[FLAG_C] = c_d;
        flags_d[FLAG_V] = v_d;
        flags_d[FLAG_N] = res_d[MSB];
        flags_d[FLAG_Z] = (res_d == '0);
    end

    // Output register stage: single-cycle results load on acceptance,
    // MUL results load on the multiplier's final iteration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept && is_mul) state_q <= ST_MUL;
                ST_MUL:  if (mul_done)         state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            if (accept && !is_mul) begin
                result_q    <= res_d;
                result_hi_q <= '0;
                flags_q     <= flags_d;
                out_valid_q <= 1'b1;
            end else if (mul_done) begin
                result_q    <= mul_lo;
                result_hi_q <= mul_hi;
                flags_q     <= mul_flags;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): the driver pushes hand-computed
// expectations when a request is accepted; a monitor pops and compares on
// every output transfer.
module tb_alu_pipe;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic [3:0] fl;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted output is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got result %0h with empty scoreboard", result);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result",    {24'd0, result},    {24'd0, mon_e.res});
                chk("result_hi", {24'd0, result_hi}, {24'd0, mon_e.hi});
                chk("flags",     {28'd0, flags},     {28'd0, mon_e.fl});
            end
        end
    end

    // Presents a request and holds it until accepted; the expectation is
    // queued at the negedge just before the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                         input logic [7:0] er, input logic [7:0] eh, input logic [3:0] ef,
                         input bit push);
        int n = 0;
        op = o; a = xa; b = xb; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: op %0d never accepted", o);
        end else if (push) begin
            sb_q.push_back('{er, eh, ef});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called right after issue(): counts edges until out_valid shows up.
    task automatic check_latency(input int exp_lat, input bit busy_chk, input string name);
        int lat     = 1;
        bit rdy_bad = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            if (busy_chk && in_ready) rdy_bad = 1'b1;
            lat++;
            @(negedge clk);
        end
        chk({name, "_latency"}, lat, exp_lat);
        if (busy_chk) chk({name, "_in_ready_low"}, {31'd0, rdy_bad}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit saw_valid;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result",    {24'd0, result},    32'd0);
        chk("rst_result_hi", {24'd0, result_hi}, 32'd0);
        chk("rst_flags",     {28'd0, flags},     32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single-cycle ops with latency checks on the first two.
        issue(4'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1001, 1'b1);
        check_latency(1, 1'b0, "add");
        issue(4'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0100, 1'b1);
        check_latency(1, 1'b0, "sub");

        // Back-to-back stream, one request per cycle.
        issue(4'd2,  8'h81, 8'h03, 8'h0C, 8'h00, 4'b0000, 1'b1); // ROL
        issue(4'd3,  8'h01, 8'h01, 8'h80, 8'h00, 4'b1010, 1'b1); // ROR
        issue(4'd11, 8'h90, 8'h02, 8'hE4, 8'h00, 4'b0010, 1'b1); // SRA
        issue(4'd2,  8'h96, 8'h08, 8'h96, 8'h00, 4'b0010, 1'b1); // ROL by 0 (upper b ignored)
        issue(4'd4,  8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1'b1); // AND
        issue(4'd5,  8'hF0, 8'h3C, 8'hCF, 8'h00, 4'b0010, 1'b1); // NAND
        issue(4'd6,  8'h0F, 8'hF0, 8'h00, 8'h00, 4'b0001, 1'b1); // NOR
        issue(4'd7,  8'h0A, 8'h50, 8'h5A, 8'h00, 4'b0000, 1'b1); // OR
        issue(4'd8,  8'hAA, 8'hAA, 8'h00, 8'h00, 4'b0001, 1'b1); // XOR
        issue(4'd9,  8'h81, 8'h01, 8'h02, 8'h00, 4'b1000, 1'b1); // SHL
        issue(4'd10, 8'h81, 8'h01, 8'h40, 8'h00, 4'b1000, 1'b1); // SHR
        issue(4'd9,  8'h55, 8'h00, 8'h55, 8'h00, 4'b0000, 1'b1); // SHL by 0
        issue(4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 4'b0110, 1'b1); // ADD overflow
        issue(4'd1,  8'h00, 8'h01, 8'hFF, 8'h00, 4'b1010, 1'b1); // SUB borrow
        issue(4'd13, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'b0001, 1'b1); // reserved
        issue(4'd15, 8'h12, 8'h34, 8'h00, 8'h00, 4'b0001, 1'b1); // reserved

        // Multiplier.
        issue(4'd12, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1100, 1'b1);
        check_latency(9, 1'b1, "mul_ff");
        issue(4'd12, 8'h10, 8'h03, 8'h30, 8'h00, 4'b0000, 1'b1);
        check_latency(9, 1'b1, "mul_small");
        issue(4'd12, 8'h10, 8'h10, 8'h00, 8'h01, 4'b1100, 1'b1);
        check_latency(9, 1'b1, "mul_lo_zero");
        issue(4'd12, 8'h00, 8'h55, 8'h00, 8'h00, 4'b0001, 1'b1);
        check_latency(9, 1'b1, "mul_zero");
        issue(4'd0,  8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, 1'b1); // ADD right after MUL

        // Output stall: second request must wait, first result must hold.
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        issue(4'd0, 8'h10, 8'h20, 8'h30, 8'h00, 4'b0000, 1'b1);
        op = 4'd0; a = 8'h40; b = 8'h50; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_result",    {24'd0, result},    32'h30);
            chk("stall_flags",     {28'd0, flags},     32'h0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(4'd0, 8'h40, 8'h50, 8'h90, 8'h00, 4'b0110, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a multiply: nothing may come out.
        issue(4'd12, 8'h12, 8'h34, 8'h00, 8'h00, 4'b0000, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_output", {31'd0, saw_valid}, 32'd0);
        @(posedge clk);
        #1;
        issue(4'd0, 8'h02, 8'h03, 8'h05, 8'h00, 4'b0000, 1'b1);
        check_latency(1, 1'b0, "add_after_abort");

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
